// File: rtl/mem_arbiter.sv
// Shares one main-memory port between icache refill (IC) and dcache refill/writeback (DC).
// Build option MEM_ARB_RR_EN: round-robin on simultaneous requests instead of fixed DC priority.
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128,
   parameter int BEATS  = 4
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  ic_req_valid,
   output logic                  ic_req_ready,
   input  logic [ADDR_W-1:0]     ic_req_addr,
   output logic                  ic_resp_valid,
   output logic [DATA_W-1:0]     ic_resp_data,

   input  logic                  dc_req_valid,
   output logic                  dc_req_ready,
   input  logic                  dc_req_rw,
   input  logic [ADDR_W-1:0]     dc_req_addr,
   input  logic                  dc_wdata_valid,
   output logic                  dc_wdata_ready,
   input  logic [DATA_W-1:0]     dc_wdata,
   input  logic [DATA_W/8-1:0]   dc_wmask,
   output logic                  dc_resp_valid,
   output logic [DATA_W-1:0]     dc_resp_data,

   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_rw,
   output logic [ADDR_W-1:0]     mem_req_addr,
   output logic                  mem_wdata_valid,
   input  logic                  mem_wdata_ready,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wmask,
   input  logic                  mem_resp_valid,
   input  logic [DATA_W-1:0]     mem_resp_data,

   output logic                  owner,
   output logic                  busy,
   output logic                  err
);

   // state | meaning
   // IDLE  | no grant; arbitrate any pending request (one cycle grant latency)
   // REQ   | owner's request forwarded, waiting for memory to accept it
   // WDATA | DC write accepted, forwarding its single write beat
   // RESP  | read accepted, routing BEATS response beats to the owner
   typedef enum logic [1:0] {IDLE, REQ, WDATA, RESP} state_t;

   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   state_t           state;
   logic [CNT_W-1:0] beat_cnt;
   logic             grant_dc;
   logic             own_valid;

   assign own_valid = owner ? dc_req_valid : ic_req_valid;

   // owner still holds the previous grant while IDLE, so it doubles as the round-robin pointer
`ifdef MEM_ARB_RR_EN
   assign grant_dc = dc_req_valid & (~ic_req_valid | ~owner);
`else
   assign grant_dc = dc_req_valid;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         beat_cnt <= '0;
         owner    <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (mem_resp_valid && (state != RESP))
            err <= 1'b1;
         case (state)
            IDLE: begin
               if (ic_req_valid || dc_req_valid) begin
                  owner <= grant_dc;
                  state <= REQ;
               end
            end
            REQ: begin
               if (!own_valid) begin
                  state <= IDLE;
               end else if (mem_req_ready) begin
                  beat_cnt <= '0;
                  state    <= (owner && dc_req_rw) ? WDATA : RESP;
               end
            end
            WDATA: begin
               if (dc_wdata_valid && mem_wdata_ready)
                  state <= IDLE;
            end
            RESP: begin
               if (mem_resp_valid) begin
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt <= '0;
                     state    <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      mem_req_valid   = 1'b0;
      ic_req_ready    = 1'b0;
      dc_req_ready    = 1'b0;
      mem_wdata_valid = 1'b0;
      dc_wdata_ready  = 1'b0;
      ic_resp_valid   = 1'b0;
      dc_resp_valid   = 1'b0;
      case (state)
         REQ: begin
            mem_req_valid = own_valid;
            ic_req_ready  = ~owner & mem_req_ready;
            dc_req_ready  = owner & mem_req_ready;
         end
         WDATA: begin
            mem_wdata_valid = dc_wdata_valid;
            dc_wdata_ready  = mem_wdata_ready;
         end
         RESP: begin
            ic_resp_valid = ~owner & mem_resp_valid;
            dc_resp_valid = owner & mem_resp_valid;
         end
         default: ;
      endcase
   end

   assign mem_req_addr = owner ? dc_req_addr : ic_req_addr;
   assign mem_req_rw   = owner & dc_req_rw;
   assign mem_wdata    = dc_wdata;
   assign mem_wmask    = dc_wmask;
   assign ic_resp_data = mem_resp_data;
   assign dc_resp_data = mem_resp_data;
   assign busy         = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path (port IC) and the data-cache refill/writeback path (port DC).
- Grants one requester at a time and forwards its request, write-data and response channels. Holds the grant until the transaction completes: a single data beat for a write, BEATS response beats for a read.
- Sits between the two cache controllers and mem_controller; provides the stall source that both caches see while the other side owns memory.

Parameters:
ADDR_W, 28, memory request address width (line address)
DATA_W, 128, memory data beat width
BEATS, 4, response beats per read transaction (>=1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
ic_req_valid  input  1  icache read request
ic_req_ready  output  1  icache request accepted
ic_req_addr  input  ADDR_W  icache line address
ic_resp_valid  output  1  response beat for icache
ic_resp_data  output  DATA_W  response data (icache)
dc_req_valid  input  1  dcache request
dc_req_ready  output  1  dcache request accepted
dc_req_rw  input  1  1=write, 0=read
dc_req_addr  input  ADDR_W  dcache line address
dc_wdata_valid  input  1  dcache write beat valid
dc_wdata_ready  output  1  dcache write beat accepted
dc_wdata  input  DATA_W  write data
dc_wmask  input  DATA_W/8  byte write mask
dc_resp_valid  output  1  response beat for dcache
dc_resp_data  output  DATA_W  response data (dcache)
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts request
mem_req_rw  output  1  forwarded rw
mem_req_addr  output  ADDR_W  forwarded address
mem_wdata_valid  output  1  write beat to memory
mem_wdata_ready  input  1  memory accepts write beat
mem_wdata  output  DATA_W  forwarded write data
mem_wmask  output  DATA_W/8  forwarded mask
mem_resp_valid  input  1  memory response beat
mem_resp_data  input  DATA_W  memory response data
owner  output  1  0=IC, 1=DC (current/last grant)
busy  output  1  state != IDLE
err  output  1  sticky: response beat arrived with no read outstanding

Behaviour:
- Clock and reset: one clock clk. reset is synchronous and active-low.
- Reset values: state=IDLE, beat_cnt=0, owner=0, err=0. All valid and ready outputs are 0.
- States: IDLE, REQ, WDATA, RESP.
- IDLE:
  - No valid or ready asserted.
  - If any req_valid is high, latch owner from the arbitration rule and go to REQ. This costs one cycle of grant latency.
  - Arbitration rule: fixed priority, DC over IC.
- REQ:
  - mem_req_valid = owner's req_valid. mem_req_addr = owner's address.
  - mem_req_rw = dc_req_rw when owner=DC, forced to 0 when owner=IC.
  - Owner's req_ready = mem_req_ready. Non-owner req_ready = 0.
  - On a handshake (valid & ready): a read goes to RESP with beat_cnt=0; a write goes to WDATA.
  - If the owner drops req_valid before the handshake (protocol violation), return to IDLE.
- WDATA:
  - mem_wdata_valid = dc_wdata_valid. dc_wdata_ready = mem_wdata_ready. Data and mask pass through combinationally.
  - On handshake, go to IDLE. Exactly one beat per write.
- RESP:
  - Owner's resp_valid = mem_resp_valid. Non-owner resp_valid = 0.
  - Both resp_data outputs always equal mem_resp_data.
  - Each beat increments beat_cnt. The beat where beat_cnt==BEATS-1 returns to IDLE and clears beat_cnt.
  - There is no backpressure on responses: the caches must accept every beat.
- mem_resp_valid outside RESP is dropped (no resp_valid pulses) and sets err.
- Outputs are combinational from state/owner plus the inputs; there is no pass-through latency beyond the IDLE grant cycle.
- Simultaneous requests in IDLE: DC wins. IC is granted in the first IDLE after DC completes, unless DC requests again (starvation is permitted in base mode).
- Back-to-back transactions: a request arriving in the completing cycle is granted in the following IDLE cycle. There is always at least one IDLE cycle between transactions.
- Reset mid-transaction: abort immediately to IDLE. beat_cnt, err and owner clear. The system resets memory in the same cycle.
- mem_req_valid never depends on mem_req_ready.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration on simultaneous requests. The requester not granted last wins; after reset, DC is preferred. A lone requester is granted regardless.
- Undefined: fixed priority, DC over IC, as above.

Test Plan:
- Single IC read, addr 0x0000040, BEATS=4, mem_req_ready=1, beats D0..D3 -> ic_req_ready pulses in cycle 2; ic_resp_valid high for exactly 4 beats; dc_resp_valid stays 0; busy drops after D3.
- DC write, addr 0x0000100, wdata 0xDEADBEEF..., wmask 0x000F, mem_wdata_ready delayed 3 cycles -> mem_req_rw=1; mem_wdata/mask match the inputs; dc_wdata_ready pulses once; returns to IDLE with no resp_valid.
- IC and DC reads asserted in the same cycle (base build) -> DC granted first; IC granted after DC's 4th beat plus one IDLE cycle. With MEM_ARB_RR_EN and last grant = DC, IC is granted first.
- Stray mem_resp_valid in IDLE -> no resp_valid pulses; err=1 and stays set until reset.
- reset=0 during beat 2 of a DC read -> next cycle IDLE, busy=0, err=0; a new IC request is then served normally with a full 4 beats.
